// File: rtl/crypt_pkg.sv
// ============================================================================
// Module  : crypt_pkg
// Brief   : Shared key-schedule constants, FSM state type and key-byte function.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package crypt_pkg;

    localparam int KEY_W   = 128;
    localparam int KBYTE_W = 8;
    localparam int KCNT_W  = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Byte index wraps so that m mod 16 == 0 selects the last key byte.
    function automatic logic [KBYTE_W-1:0] kb(input logic [KEY_W-1:0]  key,
                                              input logic [KCNT_W-1:0] m);
        logic [3:0]         idx;
        logic [KBYTE_W-1:0] sel;
        idx = m[3:0] - 4'd1;
        sel = '0;
        for (int j = 0; j < 16; j++) begin
            if (idx == 4'(j)) begin
                sel = key[KEY_W-1-KBYTE_W*j -: KBYTE_W];
            end
        end
        return {1'b0, m} ^ sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_triple_gen.sv
// ============================================================================
// Module  : key_triple_gen
// Brief   : Combinational round-key triple (K_1,K_2,K_3) for a given key and round.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_triple_gen
    import crypt_pkg::*;
#(
    parameter int ROUND_W = 6
) (
    input  logic [KEY_W-1:0]   key_i,
    input  logic [ROUND_W-1:0] round_i,
    output logic [KBYTE_W-1:0] k1_o,
    output logic [KBYTE_W-1:0] k2_o,
    output logic [KBYTE_W-1:0] k3_o
);

    logic [KCNT_W-1:0] m3_w;

    assign m3_w = KCNT_W'(round_i) * KCNT_W'(3);

    assign k1_o = kb(key_i, m3_w - KCNT_W'(2));
    assign k2_o = kb(key_i, m3_w - KCNT_W'(1));
    assign k3_o = kb(key_i, m3_w);

endmodule

`default_nettype wire

// File: rtl/key_scheduler_rev.sv
// ============================================================================
// Module  : key_scheduler_rev
// Brief   : Decrypt-side key schedule; streams round-key triples ROUNDS..1 over
//           a valid/ready handshake. Define KEY_REV_ABORT_EN for the abort port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_scheduler_rev
    import crypt_pkg::*;
#(
    parameter int ROUNDS  = 8,
    parameter int ROUND_W = 6
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               k_ready,
`ifdef KEY_REV_ABORT_EN
    input  logic               abort,
`endif
    output logic [KBYTE_W-1:0] K_1,
    output logic [KBYTE_W-1:0] K_2,
    output logic [KBYTE_W-1:0] K_3,
    output logic               k_valid,
    output logic [ROUND_W-1:0] round_idx,
    output logic               busy,
    output logic               done
);

    state_e               state_q, state_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [ROUND_W-1:0]   r_q, r_d;
    logic [KBYTE_W-1:0]   k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic                 k_valid_q, k_valid_d;
    logic                 done_q, done_d;

    logic [KEY_W-1:0]     gen_key_w;
    logic [ROUND_W-1:0]   gen_round_w;
    logic [KBYTE_W-1:0]   gen_k1_w, gen_k2_w, gen_k3_w;
    logic                 abort_w;

`ifdef KEY_REV_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // In IDLE the first triple comes straight from key_in so it is ready one cycle after start.
    assign gen_key_w   = (state_q == IDLE) ? key_in : key_q;
    assign gen_round_w = (state_q == IDLE) ? ROUND_W'(ROUNDS) : r_q - ROUND_W'(1);

    key_triple_gen #(
        .ROUND_W (ROUND_W)
    ) u_triple (
        .key_i   (gen_key_w),
        .round_i (gen_round_w),
        .k1_o    (gen_k1_w),
        .k2_o    (gen_k2_w),
        .k3_o    (gen_k3_w)
    );

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        r_d       = r_q;
        k1_d      = k1_q;
        k2_d      = k2_q;
        k3_d      = k3_q;
        k_valid_d = k_valid_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d     = key_in;
                    r_d       = ROUND_W'(ROUNDS);
                    k1_d      = gen_k1_w;
                    k2_d      = gen_k2_w;
                    k3_d      = gen_k3_w;
                    k_valid_d = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort_w) begin
                    key_d     = '0;
                    k_valid_d = 1'b0;
                    state_d   = IDLE;
                end else if (k_valid_q && k_ready) begin
                    if (r_q > ROUND_W'(1)) begin
                        r_d  = r_q - ROUND_W'(1);
                        k1_d = gen_k1_w;
                        k2_d = gen_k2_w;
                        k3_d = gen_k3_w;
                    end else begin
                        k_valid_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            key_q     <= '0;
            r_q       <= '0;
            k1_q      <= '0;
            k2_q      <= '0;
            k3_q      <= '0;
            k_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            r_q       <= r_d;
            k1_q      <= k1_d;
            k2_q      <= k2_d;
            k3_q      <= k3_d;
            k_valid_q <= k_valid_d;
            done_q    <= done_d;
        end
    end

    assign K_1       = k1_q;
    assign K_2       = k2_q;
    assign K_3       = k3_q;
    assign k_valid   = k_valid_q;
    assign round_idx = r_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_key_scheduler_rev.sv
// ============================================================================
// Module  : tb_key_scheduler_rev
// Brief   : Randomized self-checking bench for key_scheduler_rev against a
//           reference model of the reverse key schedule.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_scheduler_rev;

    localparam int ROUNDS = 8;
    localparam logic [127:0] K0 = 128'hA1B2F3E4C9D8ABCBADEFED1494126762;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         start;
    logic         k_ready;
    logic [127:0] key_in;
    logic [7:0]   K_1, K_2, K_3;
    logic         k_valid, busy, done;
    logic [5:0]   round_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    key_scheduler_rev #(
        .ROUNDS  (ROUNDS),
        .ROUND_W (6)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .key_in    (key_in),
        .k_ready   (k_ready),
        .K_1       (K_1),
        .K_2       (K_2),
        .K_3       (K_3),
        .k_valid   (k_valid),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_kb(input logic [127:0] key, input int m);
        int           i;
        logic [127:0] sh;
        i  = ((m % 16) + 15) % 16;
        sh = key >> (8 * (15 - i));
        return 8'(m) ^ sh[7:0];
    endfunction

    function automatic logic [23:0] ref_triple(input logic [127:0] key, input int r);
        return {ref_kb(key, 3*r-2), ref_kb(key, 3*r-1), ref_kb(key, 3*r)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [127:0] key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Consume a run already started; random stalls, optional start pulse at round inj_r.
    task automatic run_stream(input logic [127:0] key, input int stall_pct, input int inj_r,
                              input bit directed);
        int r   = ROUNDS;
        int cyc = 0;
        while (r >= 1 && cyc < 500) begin
            check("present", {done, busy, k_valid, round_idx, K_1, K_2, K_3},
                  {1'b0, 1'b1, 1'b1, 6'(r), ref_triple(key, r)});
            if (directed && r == 6) check("r6_wrap", {K_1, K_2, K_3}, 24'h72B0A0);
            if (directed && r == 1) check("r1_last", {K_1, K_2, K_3}, 24'hA0B0F0);
            k_ready = ($urandom_range(0, 99) >= stall_pct);
            if (r == inj_r) begin
                start  = 1'b1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            start = 1'b0;
            cyc++;
            if (k_ready) r--;
        end
        check("no_timeout", 128'(cyc < 500), 128'd1);
        check("done_pulse", {done, busy, k_valid}, 3'b100);
        check("k_hold", {K_1, K_2, K_3}, ref_triple(key, 1));
        k_ready = 1'b0;
        tick();
        check("done_clear", {done, busy, k_valid}, 3'b000);
    endtask

    initial begin
        RST_N   = 1'b0;
        start   = 1'b0;
        k_ready = 1'b0;
        key_in  = '0;
        tick();
        tick();
        check("reset", {K_1, K_2, K_3, k_valid, round_idx, busy, done}, '0);
        RST_N = 1'b1;
        tick();
        check("idle", {k_valid, busy, done}, 3'b000);

        // Directed vector with a 5-cycle stall on the first triple.
        do_start(K0);
        check("first", {k_valid, round_idx, K_1, K_2, K_3}, {1'b1, 6'd8, 24'hCEBCD3});
        for (int s = 0; s < 5; s++) begin
            k_ready = 1'b0;
            tick();
            check("stall", {k_valid, round_idx, K_1, K_2, K_3}, {1'b1, 6'd8, 24'hCEBCD3});
        end
        run_stream(K0, 0, 5, 1'b1);

        for (int n = 0; n < 6; n++) begin
            logic [127:0] k;
            k = {$urandom, $urandom, $urandom, $urandom};
            do_start(k);
            run_stream(k, 35, int'($urandom_range(0, ROUNDS)), 1'b0);
        end

        // Reset in the middle of a run.
        do_start(K0);
        k_ready = 1'b1;
        for (int c = 0; c < 20 && round_idx != 6'd4; c++) tick();
        check("reach_r4", round_idx, 6'd4);
        RST_N = 1'b0;
        #1;
        check("async_rst", {K_1, K_2, K_3, k_valid, round_idx, busy, done}, '0);
        tick();
        check("rst_no_done", {done, busy, k_valid}, 3'b000);
        RST_N = 1'b1;
        tick();
        do_start(K0);
        check("restart", {k_valid, round_idx, K_1, K_2, K_3}, {1'b1, 6'd8, 24'hCEBCD3});
        run_stream(K0, 20, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
